// File: rtl/telemetre_pkg.sv
// Shared definitions for the ultrasonic telemeter: measurement FSM states,
// default timing constants and the result width used by the distance converter.
package telemetre_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      TRIG      = 3'd1,
      WAIT_RISE = 3'd2,
      MEASURE   = 3'd3,
      DONE      = 3'd4
   } meterState_t;

   localparam int DEF_TRIG_CYCLES    = 10;
   localparam int DEF_TIMEOUT_CYCLES = 60000;
   localparam int RESULT_W           = 16;

   // Observation bundle of the echo meter internals.
   typedef struct packed {
      meterState_t state;
      logic        echoLevel;
      logic        echoRise;
      logic        echoFall;
      logic        timeoutHit;
   } meterDbg_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus history flop for an asynchronous input;
// provides the synchronized level and single-cycle rise/fall events.
module sync_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta;
   logic syncd;
   logic hist;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta  <= 1'b0;
         syncd <= 1'b0;
         hist  <= 1'b0;
      end else begin
         meta  <= sig;
         syncd <= meta;
         hist  <= syncd;
      end
   end

   assign level = syncd;
   assign rise  = syncd & ~hist;
   assign fall  = ~syncd & hist;

endmodule

// File: rtl/echo_pulse_meter.sv
// Ultrasonic echo meter: fires a trigger pulse, times the echo high phase in
// clock cycles and reports either a width (validOut) or an abort (timeoutOut).
module echo_pulse_meter
   import telemetre_pkg::*;
#(
   parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_W          = RESULT_W
) (
   input  logic             clkIn,
   input  logic             rstIn,
   input  logic             startIn,
   input  logic             echoIn,
   output logic             trigOut,
   output logic             busyOut,
   output logic [CNT_W-1:0] widthOut,
   output logic             validOut,
   output logic             timeoutOut,
   output meterDbg_t        dbgOut
);

   localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   meterState_t      state, stateNext;
   logic [CNT_W-1:0] trigCnt, trigCntNext;
   logic [CNT_W-1:0] toCnt, toCntNext;
   logic [CNT_W-1:0] widthCnt, widthCntNext;
   logic [CNT_W-1:0] widthNext;
   logic             timeoutNext;
   logic             echoLevel, echoRise, echoFall;
   logic             toHit;

   sync_edge_detect uEchoSync (
      .clk   (clkIn),
      .rst   (rstIn),
      .sig   (echoIn),
      .level (echoLevel),
      .rise  (echoRise),
      .fall  (echoFall)
   );

   assign toHit = (toCnt == TIMEOUT_LAST);

   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         state      <= IDLE;
         trigCnt    <= '0;
         toCnt      <= '0;
         widthCnt   <= '0;
         widthOut   <= '0;
         timeoutOut <= 1'b0;
      end else begin
         state      <= stateNext;
         trigCnt    <= trigCntNext;
         toCnt      <= toCntNext;
         widthCnt   <= widthCntNext;
         widthOut   <= widthNext;
         timeoutOut <= timeoutNext;
      end
   end

   // Strobes are single-cycle with no back-pressure: the consumer samples
   // widthOut on the cycle validOut (or timeoutOut) is high.
   always_comb begin
      stateNext    = state;
      trigCntNext  = trigCnt;
      toCntNext    = toCnt;
      widthCntNext = widthCnt;
      widthNext    = widthOut;
      timeoutNext  = 1'b0;
      case (state)
         IDLE: begin
            // The timeout strobe cycle is still part of the previous measurement.
            if (startIn && !timeoutOut) begin
               stateNext   = TRIG;
               trigCntNext = '0;
            end
         end
         TRIG: begin
            if (trigCnt == TRIG_LAST) begin
               stateNext = WAIT_RISE;
               toCntNext = '0;
            end else begin
               trigCntNext = trigCnt + 1'b1;
            end
         end
         WAIT_RISE: begin
            toCntNext = toCnt + 1'b1;
            if (toHit) begin
               stateNext   = IDLE;
               timeoutNext = 1'b1;
               widthNext   = '0;
            end else if (echoRise) begin
               stateNext    = MEASURE;
               widthCntNext = CNT_W'(1);
            end
         end
         MEASURE: begin
            toCntNext = toCnt + 1'b1;
            // A fall on the final timeout cycle still counts as a good echo.
            if (echoFall) begin
               stateNext = DONE;
               widthNext = widthCnt;
            end else if (toHit) begin
               stateNext   = IDLE;
               timeoutNext = 1'b1;
               widthNext   = '0;
            end else if (echoLevel) begin
               widthCntNext = widthCnt + 1'b1;
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   assign trigOut  = (state == TRIG);
   assign busyOut  = (state != IDLE);
   assign validOut = (state == DONE);

   assign dbgOut = '{state:      state,
                     echoLevel:  echoLevel,
                     echoRise:   echoRise,
                     echoFall:   echoFall,
                     timeoutHit: toHit};

endmodule

// File: tb/tb_echo_pulse_meter.sv
// Bench for echo_pulse_meter: directed echo scenarios on two instances
// (default timeout and a short 100-cycle timeout) with a queue scoreboard.
module tb_echo_pulse_meter;
   import telemetre_pkg::*;

   localparam int CNT_W = 16;
   localparam int W     = CNT_W + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             startA, echoA, startB, echoB;
   logic             trigA, busyA, validA, toA;
   logic             trigB, busyB, validB, toB;
   logic [CNT_W-1:0] widthA, widthB;
   meterDbg_t        dbgA, dbgB;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // expected entry: {isTimeout, width}, plus the cycle the strobe must appear
   logic [W-1:0] expA_q[$];
   logic [W-1:0] expB_q[$];
   int           cycA_q[$];
   int           cycB_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   echo_pulse_meter uDutA (
      .clkIn(clk), .rstIn(rst), .startIn(startA), .echoIn(echoA),
      .trigOut(trigA), .busyOut(busyA), .widthOut(widthA),
      .validOut(validA), .timeoutOut(toA), .dbgOut(dbgA)
   );

   echo_pulse_meter #(.TIMEOUT_CYCLES(100)) uDutB (
      .clkIn(clk), .rstIn(rst), .startIn(startB), .echoIn(echoB),
      .trigOut(trigB), .busyOut(busyB), .widthOut(widthB),
      .validOut(validB), .timeoutOut(toB), .dbgOut(dbgB)
   );

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic judge(input string tag, input logic v, input logic t, input logic busy,
                        input logic [CNT_W-1:0] w, input logic [W-1:0] e, input int ec);
      check({tag, "_timeout_flag"}, t, e[CNT_W]);
      check({tag, "_width"}, w, e[CNT_W-1:0]);
      check({tag, "_cycle"}, cyc, ec);
      if (v) check({tag, "_busy_on_valid"}, busy, 1);
   endtask

   // ---------------- monitors / scoreboard ----------------
   always @(negedge clk) begin
      if (validA || toA) begin
         check("a_strobe_overlap", validA & toA, 0);
         if (expA_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected_strobe: got valid=%0b timeout=%0b width=%0d, expected none",
                     validA, toA, widthA);
         end else begin
            judge("a", validA, toA, busyA, widthA, expA_q.pop_front(), cycA_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (validB || toB) begin
         check("b_strobe_overlap", validB & toB, 0);
         if (expB_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected_strobe: got valid=%0b timeout=%0b width=%0d, expected none",
                     validB, toB, widthB);
         end else begin
            judge("b", validB, toB, busyB, widthB, expB_q.pop_front(), cycB_q.pop_front());
         end
      end
   end

   int runA = 0;
   int runB = 0;
   always @(negedge clk) begin
      if (trigA) runA++;
      else begin
         if (runA != 0) check("a_trig_len", runA, 10);
         runA = 0;
      end
      if (trigB) runB++;
      else begin
         if (runB != 0) check("b_trig_len", runB, 10);
         runB = 0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic ticks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Raise start for one sampling edge; k returns that edge's cycle number.
   task automatic startPulse(input bit onB, output int k);
      if (onB) startB = 1'b1;
      else     startA = 1'b1;
      @(negedge clk);
      startA = 1'b0;
      startB = 1'b0;
      k = cyc;
   endtask

   task automatic expectB(input logic isTo, input int width, input int atCyc);
      expB_q.push_back({isTo, CNT_W'(width)});
      cycB_q.push_back(atCyc);
   endtask

   task automatic checkIdle(input string tag, input logic t, input logic b, input logic v,
                            input logic o, input logic [CNT_W-1:0] w, input meterDbg_t d);
      check({tag, "_trig"}, t, 0);
      check({tag, "_busy"}, b, 0);
      check({tag, "_valid"}, v, 0);
      check({tag, "_timeout"}, o, 0);
      check({tag, "_width"}, w, 0);
      check({tag, "_state"}, int'(d.state), int'(IDLE));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int k;
      rst = 1'b1; startA = 1'b0; echoA = 1'b0; startB = 1'b0; echoB = 1'b0;
      ticks(3);
      checkIdle("a_reset", trigA, busyA, validA, toA, widthA, dbgA);
      checkIdle("b_reset", trigB, busyB, validB, toB, widthB, dbgB);
      rst = 1'b0;

      // echo activity while idle must produce nothing
      for (int i = 0; i < 8; i++) begin
         echoA = ~echoA;
         echoB = ~echoB;
         ticks(3);
      end
      echoA = 1'b0; echoB = 1'b0;
      ticks(4);
      check("a_idle_busy", busyA, 0);
      check("b_idle_busy", busyB, 0);

      // nominal: echo high 500 cycles, 20 cycles after trigger end (edge k+10)
      startPulse(1'b0, k);
      ticks(30); echoA = 1'b1;     // first high sample at k+31
      ticks(500); echoA = 1'b0;    // first low sample at k+531
      expA_q.push_back({1'b0, 16'd500});
      cycA_q.push_back(k + 533);
      ticks(10);

      // no echo: WAIT_RISE from k+10, timeout strobe at k+110
      startPulse(1'b1, k);
      expectB(1'b1, 0, k + 110);
      ticks(111);
      check("b_noecho_busy_after", busyB, 0);
      ticks(3);

      // echo already high through trigger, falls, then a 40-cycle echo
      startPulse(1'b1, k);
      echoB = 1'b1;
      ticks(14); echoB = 1'b0;
      ticks(5);  echoB = 1'b1;     // high samples k+20..k+59
      ticks(40); echoB = 1'b0;
      expectB(1'b0, 40, k + 62);
      ticks(6);

      // echo stuck high: timeout from MEASURE
      startPulse(1'b1, k);
      ticks(20); echoB = 1'b1;
      expectB(1'b1, 0, k + 110);
      ticks(91); echoB = 1'b0;
      ticks(5);

      // 88-cycle echo: fall event lands one cycle after the last timeout cycle
      startPulse(1'b1, k);
      ticks(20); echoB = 1'b1;
      ticks(88); echoB = 1'b0;
      expectB(1'b1, 0, k + 110);
      ticks(8);

      // 87-cycle echo: fall event coincides with the last timeout cycle
      startPulse(1'b1, k);
      ticks(20); echoB = 1'b1;
      ticks(87); echoB = 1'b0;
      expectB(1'b0, 87, k + 110);
      ticks(8);
      check("b_width_held", widthB, 87);

      // start during MEASURE is ignored, then reset mid-measurement
      startPulse(1'b1, k);
      ticks(20); echoB = 1'b1;
      ticks(20); startB = 1'b1;
      ticks(1);  startB = 1'b0;
      check("b_start_ignored_trig", trigB, 0);
      check("b_start_ignored_busy", busyB, 1);
      ticks(9); rst = 1'b1;
      ticks(1); rst = 1'b0;
      checkIdle("b_midreset", trigB, busyB, validB, toB, widthB, dbgB);
      check("a_midreset_width", widthA, 0);
      ticks(3); echoB = 1'b0;
      ticks(20);

      // recovery after reset with a single-cycle echo
      startPulse(1'b1, k);
      ticks(15); echoB = 1'b1;     // single high sample at k+16
      ticks(1);  echoB = 1'b0;
      expectB(1'b0, 1, k + 19);
      ticks(10);

      check("a_queue_drained", expA_q.size(), 0);
      check("b_queue_drained", expB_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/echo_pulse_meter.md
# echo_pulse_meter

Measures the echo pulse of the ultrasonic telemeter, complementing the clock/trigger generation side. On a start request it emits a fixed-length trigger pulse, waits for the sensor's echo line to rise, counts the echo high time in `clkIn` cycles and reports it with a one-cycle valid strobe. If no complete echo arrives in time, it reports a timeout instead. Downstream distance-conversion logic consumes `widthOut`.

## Interface
- `TRIG_CYCLES`, 10: trigger pulse length in `clkIn` cycles (≥1)
- `TIMEOUT_CYCLES`, 60000: maximum cycles from end of trigger to echo fall (≥2, < 2^`CNT_W`)
- `CNT_W`, 16: width of measurement and timeout counters in bits

- `clkIn`  in  1  single clock, all logic on rising edge
- `rstIn`  in  1  synchronous, active-high reset
- `startIn`  in  1  measurement request, sampled only in IDLE
- `echoIn`  in  1  asynchronous echo line from sensor
- `trigOut`  out  1  trigger pulse to sensor, active high
- `busyOut`  out  1  high whenever state ≠ IDLE
- `widthOut`  out  `CNT_W`  last measured echo width in cycles, held until next result
- `validOut`  out  1  one-cycle strobe: new `widthOut`
- `timeoutOut`  out  1  one-cycle strobe: measurement aborted

## Operation
- Reset values: `trigOut`=0, `busyOut`=0, `widthOut`=0, `validOut`=0, `timeoutOut`=0, state IDLE, counters 0, synchronizer flops 0.
- `echoIn` passes through a 2-flop synchronizer (`echoS`) plus one history flop (`echoP`); rise = `echoS & ~echoP`, fall = `~echoS & echoP`.
- FSM states:
  - IDLE: `startIn`=1 → TRIG, trigger counter cleared.
  - TRIG: `trigOut`=1; after `TRIG_CYCLES` cycles → WAIT_RISE, timeout counter cleared.
  - WAIT_RISE: echo level high on entry is ignored; only a rise event → MEASURE with width counter loaded to 1.
  - MEASURE: width counter +1 each cycle `echoS`=1; fall event → DONE.
  - DONE: `widthOut` ← width counter, `validOut`=1 for one cycle → IDLE.
- Timeout counter increments every cycle in WAIT_RISE and MEASURE; when it reaches `TIMEOUT_CYCLES`−1 without a fall event: `timeoutOut`=1 one cycle, `widthOut` ← 0, → IDLE.
- Fall event and timeout in the same cycle: fall wins, normal DONE path, no `timeoutOut`.
- `startIn` while busy: ignored, no queuing.
- `rstIn` mid-operation: all outputs and state to reset values at that edge; `trigOut` drops immediately, no strobe emitted.
- Width counter cannot overflow because `TIMEOUT_CYCLES` < 2^`CNT_W`.

## Timing
- `startIn` high at edge k (IDLE): `trigOut`, `busyOut` high from k+1 through k+`TRIG_CYCLES`; WAIT_RISE from k+`TRIG_CYCLES`+1.
- Echo synchronizer latency 2 cycles; a glitch-free echo high for N cycles yields `widthOut`=N exactly.
- `validOut` asserts 3 edges after the first edge sampling `echoIn` low (sync 2 + DONE register 1); `busyOut` falls the cycle after `validOut`.
- Earliest next `startIn` accepted: the cycle after `validOut`/`timeoutOut`.
- `validOut` and `timeoutOut` never high together.

## Structure
- Shared package `telemetre_pkg`: FSM state enumeration (IDLE, TRIG, WAIT_RISE, MEASURE, DONE), default parameter constants, result width constant shared with the distance converter.
- One sub-module: `sync_edge_detect` (2-flop synchronizer + history flop, outputs level, rise, fall; synchronous reset to 0), reusable for other sensor inputs.
- FSM, trigger/width/timeout counters in the top module.

## Test plan
- Reset then idle: `rstIn`=1 for 3 cycles → all outputs 0; `echoIn` toggling while IDLE → no strobes.
- Nominal: `startIn` pulse, `echoIn` high 500 cycles starting 20 cycles after trigger end → `trigOut` high exactly 10 cycles, `validOut` once, `widthOut`=500, no `timeoutOut`.
- No echo: `startIn`, `echoIn` held 0 with `TIMEOUT_CYCLES`=100 → `timeoutOut` one cycle 100 cycles after WAIT_RISE entry, `widthOut`=0, `busyOut` then 0.
- Echo already high at WAIT_RISE entry, falls, rises again for 40 cycles → `widthOut`=40 (initial high ignored).
- Echo stuck high past timeout (`TIMEOUT_CYCLES`=100) → `timeoutOut`, `widthOut`=0; falling edge coincident with last timeout cycle → `validOut` instead.
- `startIn` asserted during MEASURE and `rstIn` pulsed mid-MEASURE → start ignored; after reset `trigOut`=0, `busyOut`=0, no strobe, `widthOut`=0.
